// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction, response and ALU-facing signals of alu_issue_ctrl.
// The master modport is the side that issues instructions and provides the ALU.
interface alu_issue_ctrl_if #(
    parameter int NREG   = 8,
    parameter int DATA_W = 32
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [AW-1:0]     in_rd;
    logic [AW-1:0]     in_rs1;
    logic [AW-1:0]     in_rs2;
    logic              in_imm_sel;
    logic [DATA_W-1:0] in_imm;

    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_flagC;
    logic              alu_flagZ;

    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_rd;
    logic [DATA_W-1:0] out_data;
    logic              out_flagC;
    logic              out_flagZ;
    logic              out_err;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm_sel, in_imm,
        input  in_ready,
        input  alu_opcode, alu_a, alu_b,
        output alu_result, alu_flagC, alu_flagZ,
        input  out_valid, out_rd, out_data, out_flagC, out_flagZ, out_err,
        output out_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm_sel, in_imm,
        output in_ready,
        output alu_opcode, alu_a, alu_b,
        input  alu_result, alu_flagC, alu_flagZ,
        output out_valid, out_rd, out_data, out_flagC, out_flagZ, out_err,
        input  out_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue register-machine front end for the combinational alu32bit:
// reads operands from a small register file, runs one ALU cycle, writes back, responds.
module alu_issue_ctrl #(
    parameter int NREG   = 8,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.slave  bus
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [3:0]        r_op;
    logic [AW-1:0]     r_rd;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_data;
    logic              r_flag_c;
    logic              r_flag_z;
    logic              r_err;
    logic [DATA_W-1:0] r_rf [NREG];

    logic              w_accept;
    logic              w_illegal;
    logic              w_in_ready;
    logic              w_out_valid;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;

    // r0 is masked on read so it reads zero regardless of storage contents
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (bus.in_rs1 != '0) w_rs1_val = r_rf[bus.in_rs1];
        if (bus.in_rs2 != '0) w_rs2_val = r_rf[bus.in_rs2];
    end

    assign w_illegal = (bus.in_opcode >= 4'd13);
    assign w_accept  = bus.in_valid && (r_state == S_IDLE);

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = w_illegal ? S_RESP : S_EXEC;
            end
            S_EXEC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Operands are only loaded for legal opcodes so the ALU inputs stay quiet on errors
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= '0;
            r_rd <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_rd <= bus.in_rd;
            if (!w_illegal) begin
                r_op <= bus.in_opcode;
                r_a  <= w_rs1_val;
                r_b  <= bus.in_imm_sel ? bus.in_imm : w_rs2_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_data   <= '0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
            r_err    <= w_illegal;
        end else if (r_state == S_EXEC) begin
            r_data   <= bus.alu_result;
            r_flag_c <= bus.alu_flagC;
            r_flag_z <= bus.alu_flagZ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if ((r_state == S_EXEC) && (r_rd != '0)) begin
            r_rf[r_rd] <= bus.alu_result;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.alu_opcode = r_op;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.out_rd     = r_rd;
    assign bus.out_data   = r_data;
    assign bus.out_flagC  = r_flag_c;
    assign bus.out_flagZ  = r_flag_z;
    assign bus.out_err    = r_err;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; a small ADD/SUB model stands in for alu32bit.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   prev_acc = 0;
    int   n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl_if #(.NREG(8), .DATA_W(32)) bus ();

    alu_issue_ctrl #(.NREG(8), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in ALU: 0000 ADD, 0001 SUB (carry = no borrow), otherwise AND
    always_comb begin
        logic [32:0] s;
        case (bus.alu_opcode)
            4'b0000: s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'b0001: s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
            default: s = {1'b0, bus.alu_a & bus.alu_b};
        endcase
        bus.alu_result = s[31:0];
        bus.alu_flagC  = s[32];
        bus.alu_flagZ  = (s[31:0] == 32'd0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic sel, input logic [31:0] imm);
        int w;
        bus.in_opcode  = op;
        bus.in_rd      = rd;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_imm_sel = sel;
        bus.in_imm     = imm;
        bus.in_valid   = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 10) begin
            step();
            w++;
        end
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
    endtask

    task automatic resp(input string tag, input int exp_lat, input logic [2:0] rd,
                        input logic [31:0] data, input logic c, input logic z, input logic err);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            chk({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
            step();
            lat++;
        end
        chk({tag, "_lat"},    64'(lat), 64'(exp_lat));
        chk({tag, "_valid"},  64'(bus.out_valid), 64'd1);
        chk({tag, "_rdy_lo"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_rd"},     64'(bus.out_rd), 64'(rd));
        chk({tag, "_data"},   64'(bus.out_data), 64'(data));
        chk({tag, "_C"},      64'(bus.out_flagC), 64'(c));
        chk({tag, "_Z"},      64'(bus.out_flagZ), 64'(z));
        chk({tag, "_err"},    64'(bus.out_err), 64'(err));
        step();
        chk({tag, "_done"},   64'(bus.out_valid), 64'd0);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic sel,
                       input logic [31:0] imm, input int exp_lat, input logic [31:0] data,
                       input logic c, input logic z, input logic err);
        issue(tag, op, rd, rs1, rs2, sel, imm);
        resp(tag, exp_lat, rd, data, c, z, err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_opcode  = '0;
        bus.in_rd      = '0;
        bus.in_rs1     = '0;
        bus.in_rs2     = '0;
        bus.in_imm_sel = 1'b0;
        bus.in_imm     = '0;
        bus.out_ready  = 1'b1;
        rst            = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_err",   64'(bus.out_err), 64'd0);
        chk("rst_out_rd",    64'(bus.out_rd), 64'd0);
        chk("rst_out_data",  64'(bus.out_data), 64'd0);
        chk("rst_out_C",     64'(bus.out_flagC), 64'd0);
        chk("rst_out_Z",     64'(bus.out_flagZ), 64'd0);
        chk("rst_alu_op",    64'(bus.alu_opcode), 64'd0);
        chk("rst_alu_a",     64'(bus.alu_a), 64'd0);
        chk("rst_alu_b",     64'(bus.alu_b), 64'd0);
        step();
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // ADD r1,r0,#100 ; ADD r2,r0,#50
        run("add_r1", 4'b0000, 3'd1, 3'd0, 3'd0, 1'b1, 32'd100, 2, 32'd100, 1'b0, 1'b0, 1'b0);
        run("add_r2", 4'b0000, 3'd2, 3'd0, 3'd0, 1'b1, 32'd50,  2, 32'd50,  1'b0, 1'b0, 1'b0);
        chk("legal_spacing", 64'(acc_cyc - prev_acc), 64'd3);

        // SUB r3,r1,r2 = 50 ; SUB r4,r2,r2 = 0
        run("sub_r3", 4'b0001, 3'd3, 3'd1, 3'd2, 1'b0, 32'hDEAD, 2, 32'd50, 1'b1, 1'b0, 1'b0);
        run("sub_r4", 4'b0001, 3'd4, 3'd2, 3'd2, 1'b0, 32'd0,    2, 32'd0,  1'b1, 1'b1, 1'b0);

        // Dependent back-to-back: r5 = FFFFFFFF, r6 = r5 + 1
        run("add_r5", 4'b0000, 3'd5, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run("add_r6", 4'b0000, 3'd6, 3'd5, 3'd0, 1'b1, 32'd1, 2, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("dep_spacing", 64'(acc_cyc - prev_acc), 64'd3);

        // Backpressure: ADD r7,r1,#5 held 5 cycles, with ignored in_valid pulses to r3
        bus.out_ready = 1'b0;
        issue("bp", 4'b0000, 3'd7, 3'd1, 3'd0, 1'b1, 32'd5);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            step();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_data", 64'(bus.out_data), 64'd105);
            chk("bp_flags", 64'({bus.out_flagC, bus.out_flagZ}), 64'd0);
            chk("bp_rd", 64'(bus.out_rd), 64'd7);
            bus.in_opcode  = 4'b0000;
            bus.in_rd      = 3'd3;
            bus.in_rs1     = 3'd0;
            bus.in_imm_sel = 1'b1;
            bus.in_imm     = 32'h55;
            bus.in_valid   = k[0] ? 1'b0 : 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        chk("bp_still_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        step();
        chk("bp_release", 64'(bus.out_valid), 64'd0);
        chk("bp_idle_rdy", 64'(bus.in_ready), 64'd1);
        run("bp_r3_kept", 4'b0000, 3'd4, 3'd3, 3'd0, 1'b1, 32'd0, 2, 32'd50, 1'b0, 1'b0, 1'b0);
        run("bp_r7_wr",   4'b0000, 3'd2, 3'd7, 3'd0, 1'b1, 32'd0, 2, 32'd105, 1'b0, 1'b0, 1'b0);

        // Illegal opcode 1110 to r1, then ADD r2,r1,#0 still sees 100
        run("illegal", 4'b1110, 3'd1, 3'd1, 3'd1, 1'b1, 32'd3, 1, 32'd0, 1'b0, 1'b0, 1'b1);
        run("after_ill", 4'b0000, 3'd2, 3'd1, 3'd0, 1'b1, 32'd0, 2, 32'd100, 1'b0, 1'b0, 1'b0);
        chk("illegal_spacing", 64'(acc_cyc - prev_acc), 64'd2);
        run("illegal_1101", 4'b1101, 3'd5, 3'd1, 3'd1, 1'b0, 32'd0, 1, 32'd0, 1'b0, 1'b0, 1'b1);

        // Write to r0 is discarded but reported
        run("wr_r0",  4'b0000, 3'd0, 3'd0, 3'd0, 1'b1, 32'd7, 2, 32'd7, 1'b0, 1'b0, 1'b0);
        run("rd_r0",  4'b0000, 3'd3, 3'd0, 3'd0, 1'b1, 32'd0, 2, 32'd0, 1'b0, 1'b1, 1'b0);

        // Reset during EXEC of ADD r1,r0,#9
        issue("mid_rst", 4'b0000, 3'd1, 3'd0, 3'd0, 1'b1, 32'd9);
        chk("mid_rst_exec", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_rdy", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_nov", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_alu_a", 64'(bus.alu_a), 64'd0);
        step();
        chk("mid_rst_nov2", 64'(bus.out_valid), 64'd0);
        run("post_rst", 4'b0000, 3'd2, 3'd1, 3'd0, 1'b1, 32'd0, 2, 32'd0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing front end that sits directly upstream of `alu32bit`. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file. It drives the ALU's `opcode`/`a`/`b` ports from registers, captures `result`/`flagC`/`flagZ`, writes the result back, and returns a response over a second valid/ready handshake. This lets the combinational ALU be exercised as a small register machine.

## Interface
- `NREG`, default 8: register-file depth (r0 hardwired zero).
- `DATA_W`, default 32: datapath width; must equal the ALU width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: block can accept an instruction.
- `in_opcode` in 4: ALU opcode (encoding identical to `alu32bit`).
- `in_rd` in log2(NREG): destination register.
- `in_rs1` in log2(NREG): source A register.
- `in_rs2` in log2(NREG): source B register.
- `in_imm_sel` in 1: 1 = operand B is `in_imm`; 0 = operand B is `rs2`.
- `in_imm` in DATA_W: immediate operand.
- `alu_opcode` out 4: to ALU `opcode`.
- `alu_a` out DATA_W: to ALU `a`.
- `alu_b` out DATA_W: to ALU `b`.
- `alu_result` in DATA_W: from ALU `result`.
- `alu_flagC` in 1: from ALU `flagC`.
- `alu_flagZ` in 1: from ALU `flagZ`.
- `out_valid` out 1: response present.
- `out_ready` in 1: consumer accepts the response.
- `out_rd` out log2(NREG): destination of the completed instruction.
- `out_data` out DATA_W: captured result (0 on error).
- `out_flagC` out 1: captured carry.
- `out_flagZ` out 1: captured zero.
- `out_err` out 1: illegal opcode (4'b1101–4'b1111).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `in_ready`=1. On `in_valid & in_ready`:
  - Latch opcode, rd, A = RF[rs1], and B = `in_imm_sel` ? `in_imm` : RF[rs2] into the issue registers.
  - Go to EXEC. Illegal opcodes go directly to RESP with `out_err`=1.
- EXEC (exactly 1 cycle): `alu_opcode`/`alu_a`/`alu_b` are driven from the issue registers. At the end of the cycle, capture `alu_result`, `alu_flagC`, and `alu_flagZ` into the output registers and write RF[rd] = `alu_result`. Then go to RESP.
- RESP: `out_valid`=1. Outputs are held stable until `out_valid & out_ready`, then go to IDLE.
- `in_ready`=0 in EXEC and RESP; no instruction is buffered.
- r0 always reads 0. Writes to r0 are discarded, but the response is still produced with the real ALU result.
- Illegal opcode: no ALU cycle and no RF write. Response has `out_data`=0, `out_flagC`=0, `out_flagZ`=0, `out_err`=1.
- Flags are passed through from the ALU unmodified. No flag state persists between instructions.

## Timing
- Reset values:
  - State = IDLE; `in_ready`=1 from the first cycle after reset.
  - `out_valid`=0, `out_err`=0, `out_rd`=0, `out_data`=0, `out_flagC`=0, `out_flagZ`=0.
  - `alu_opcode`=0, `alu_a`=0, `alu_b`=0.
  - All RF entries = 0.
- Legal instruction accepted at edge k: EXEC is cycle k→k+1, and `out_valid` is 1 in the cycle after edge k+1.
- Illegal instruction accepted at edge k: `out_valid` is 1 in the cycle after edge k.
- With `out_ready` held high, accept-to-accept spacing is 3 cycles for legal instructions and 2 for illegal ones.
- RF write happens at the EXEC→RESP edge. The next instruction is accepted no earlier than the RESP→IDLE edge, so it always reads the updated value; no bypass is needed.
- RF reads in IDLE are combinational from `in_rs1`/`in_rs2`, sampled at the accept edge.
- Reset asserted in any state (including EXEC or RESP with `out_ready`=0):
  - Abandon the instruction and clear the RF.
  - No response is produced, and no RF write survives.
- `out_ready` asserted while `out_valid`=0: ignored.

## Test plan
- Reset, then ADD r1,r0,#100 (`in_opcode`=0000, `in_imm_sel`=1). Expect:
  - `in_ready` drops for 2 cycles.
  - `out_valid` on the 2nd cycle after accept with `out_rd`=1, `out_data`=100, `out_flagZ`=0, `out_err`=0.
- Load r1=100 and r2=50 by immediate, then SUB r3,r1,r2. Expect `out_data`=50. Then SUB r4,r2,r2: expect `out_data`=0 and `out_flagZ`=1.
- Dependent back-to-back: ADD r5,r0,#0xFFFFFFFF, then ADD r6,r5,#1 issued at the first `in_ready`. Expect `out_data`=0, `out_flagC`=1, `out_flagZ`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises. Expect:
  - `out_valid`=1, `in_ready`=0, and `out_data`/flags stable throughout.
  - `in_valid` pulses in this window are not accepted.
  - Handshake completes on the first `out_ready`=1.
- Illegal opcode 1110 to r1 (r1=100 beforehand). Expect `out_valid` 1 cycle after accept with `out_err`=1 and `out_data`=0. A following ADD r2,r1,#0 returns 100.
- Write to r0 / reset mid-operation:
  - ADD r0,r0,#7 returns `out_data`=7; a following ADD r3,r0,#0 returns 0.
  - Assert `rst` during EXEC of ADD r1,r0,#9. Expect no `out_valid` and `in_ready`=1 after release; a following ADD r2,r1,#0 returns 0.
